// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with stall hold, bubble insertion and a saturating bubble counter.
// Define WB_BYPASS_EN to add the same-cycle write-back bypass on the RD1/RD2 operands.
module id_ex_pipe #(
  parameter int N  = 32,
  parameter int RN = 5,
  parameter int CN = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [N-1:0]  pc_in,
  input  logic [N-1:0]  rd1_in,
  input  logic [N-1:0]  rd2_in,
  input  logic [N-1:0]  imm_in,
  input  logic [RN-1:0] rs1_in,
  input  logic [RN-1:0] rs2_in,
  input  logic [RN-1:0] rd_in,
  input  logic [CN-1:0] ctrl_in,
  input  logic          wb_reg_write,
  input  logic [RN-1:0] wb_rd,
  input  logic [N-1:0]  wb_data,
  output logic          ex_valid,
  output logic [N-1:0]  pc_ex,
  output logic [N-1:0]  rd1_ex,
  output logic [N-1:0]  rd2_ex,
  output logic [N-1:0]  imm_ex,
  output logic [RN-1:0] rs1_ex,
  output logic [RN-1:0] rs2_ex,
  output logic [RN-1:0] rd_ex,
  output logic [CN-1:0] ctrl_ex,
  output logic [15:0]   bubble_cnt
);

  logic          r_valid;
  logic [N-1:0]  r_pc;
  logic [N-1:0]  r_rd1;
  logic [N-1:0]  r_rd2;
  logic [N-1:0]  r_imm;
  logic [RN-1:0] r_rs1;
  logic [RN-1:0] r_rs2;
  logic [RN-1:0] r_rd;
  logic [CN-1:0] r_ctrl;
  logic [15:0]   r_bubble_cnt;

  logic          w_load_bubble;
  logic          w_load_instr;
  logic [N-1:0]  w_rd1_sel;
  logic [N-1:0]  w_rd2_sel;

  // Edge action decode: flush beats stall, stall beats an idle ID stage.
  always_comb begin
    w_load_bubble = 1'b0;
    w_load_instr  = 1'b0;
    if (flush) begin
      w_load_bubble = 1'b1;
    end else if (stall) begin
      w_load_bubble = 1'b0;
      w_load_instr  = 1'b0;
    end else if (!id_valid) begin
      w_load_bubble = 1'b1;
    end else begin
      w_load_instr  = 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  // The register file still shows the pre-write value this cycle; forward WB data, never for x0.
  always_comb begin
    w_rd1_sel = rd1_in;
    w_rd2_sel = rd2_in;
    if (wb_reg_write && (wb_rd == rs1_in) && (rs1_in != {RN{1'b0}})) begin
      w_rd1_sel = wb_data;
    end else begin
      w_rd1_sel = rd1_in;
    end
    if (wb_reg_write && (wb_rd == rs2_in) && (rs2_in != {RN{1'b0}})) begin
      w_rd2_sel = wb_data;
    end else begin
      w_rd2_sel = rd2_in;
    end
  end
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_reg_write, wb_rd, wb_data};

  // Without the bypass the operands come straight from the register file.
  always_comb begin
    w_rd1_sel = rd1_in;
    w_rd2_sel = rd2_in;
  end
`endif

  // Stage registers: bubble zeroes everything, stall holds, otherwise capture ID.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid      <= 1'b0;
      r_pc         <= {N{1'b0}};
      r_rd1        <= {N{1'b0}};
      r_rd2        <= {N{1'b0}};
      r_imm        <= {N{1'b0}};
      r_rs1        <= {RN{1'b0}};
      r_rs2        <= {RN{1'b0}};
      r_rd         <= {RN{1'b0}};
      r_ctrl       <= {CN{1'b0}};
      r_bubble_cnt <= 16'h0000;
    end else if (w_load_bubble) begin
      r_valid <= 1'b0;
      r_pc    <= {N{1'b0}};
      r_rd1   <= {N{1'b0}};
      r_rd2   <= {N{1'b0}};
      r_imm   <= {N{1'b0}};
      r_rs1   <= {RN{1'b0}};
      r_rs2   <= {RN{1'b0}};
      r_rd    <= {RN{1'b0}};
      r_ctrl  <= {CN{1'b0}};
      if (r_bubble_cnt != 16'hFFFF) begin
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
      end else begin
        r_bubble_cnt <= r_bubble_cnt;
      end
    end else if (w_load_instr) begin
      r_valid <= 1'b1;
      r_pc    <= pc_in;
      r_rd1   <= w_rd1_sel;
      r_rd2   <= w_rd2_sel;
      r_imm   <= imm_in;
      r_rs1   <= rs1_in;
      r_rs2   <= rs2_in;
      r_rd    <= rd_in;
      r_ctrl  <= ctrl_in;
    end else begin
      r_valid      <= r_valid;
      r_bubble_cnt <= r_bubble_cnt;
    end
  end

  assign ex_valid   = r_valid;
  assign pc_ex      = r_pc;
  assign rd1_ex     = r_rd1;
  assign rd2_ex     = r_rd2;
  assign imm_ex     = r_imm;
  assign rs1_ex     = r_rs1;
  assign rs2_ex     = r_rs2;
  assign rd_ex      = r_rd;
  assign ctrl_ex    = r_ctrl;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed steps plus randomized traffic for id_ex_pipe, checked against a priority-list model.
// Model follows WB_BYPASS_EN the same way the design build does.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] pc_in = 32'h0;
  logic [31:0] rd1_in = 32'h0;
  logic [31:0] rd2_in = 32'h0;
  logic [31:0] imm_in = 32'h0;
  logic [4:0]  rs1_in = 5'h0;
  logic [4:0]  rs2_in = 5'h0;
  logic [4:0]  rd_in = 5'h0;
  logic [11:0] ctrl_in = 12'h0;
  logic        wb_reg_write = 1'b0;
  logic [4:0]  wb_rd = 5'h0;
  logic [31:0] wb_data = 32'h0;

  logic        ex_valid;
  logic [31:0] pc_ex, rd1_ex, rd2_ex, imm_ex;
  logic [4:0]  rs1_ex, rs2_ex, rd_ex;
  logic [11:0] ctrl_ex;
  logic [15:0] bubble_cnt;

  // Reference state: what the EX stage should hold.
  logic        e_valid;
  logic [31:0] e_pc, e_rd1, e_rd2, e_imm;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic [11:0] e_ctrl;
  int          e_cnt;

  int checks = 0;
  int passed = 0;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  id_ex_pipe dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .pc_in(pc_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in), .ctrl_in(ctrl_in),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .pc_ex(pc_ex), .rd1_ex(rd1_ex), .rd2_ex(rd2_ex),
    .imm_ex(imm_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .ctrl_ex(ctrl_ex), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear(input bit clr_cnt);
    e_valid = 1'b0; e_pc = 32'h0; e_rd1 = 32'h0; e_rd2 = 32'h0; e_imm = 32'h0;
    e_rs1 = 5'h0; e_rs2 = 5'h0; e_rd = 5'h0; e_ctrl = 12'h0;
    if (clr_cnt) e_cnt = 0;
  endtask

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
    if (BYPASS && wb_reg_write && rs != 5'd0 && rs == wb_rd) return wb_data;
    return rf;
  endfunction

  task automatic model_edge();
    if (!rst) begin
      model_clear(1'b1);
    end else if (flush || (!stall && !id_valid)) begin
      model_clear(1'b0);
      e_cnt = (e_cnt >= 65535) ? 65535 : e_cnt + 1;
    end else if (!stall) begin
      e_valid = 1'b1; e_pc = pc_in; e_imm = imm_in; e_ctrl = ctrl_in;
      e_rd1 = operand(rs1_in, rd1_in); e_rd2 = operand(rs2_in, rd2_in);
      e_rs1 = rs1_in; e_rs2 = rs2_in; e_rd = rd_in;
    end
  endtask

  task automatic check_all();
    chk("ex_valid", {63'd0, ex_valid}, {63'd0, e_valid});
    chk("pc_ex", {32'd0, pc_ex}, {32'd0, e_pc});
    chk("rd1_ex", {32'd0, rd1_ex}, {32'd0, e_rd1});
    chk("rd2_ex", {32'd0, rd2_ex}, {32'd0, e_rd2});
    chk("imm_ex", {32'd0, imm_ex}, {32'd0, e_imm});
    chk("rs1_ex", {59'd0, rs1_ex}, {59'd0, e_rs1});
    chk("rs2_ex", {59'd0, rs2_ex}, {59'd0, e_rs2});
    chk("rd_ex", {59'd0, rd_ex}, {59'd0, e_rd});
    chk("ctrl_ex", {52'd0, ctrl_ex}, {52'd0, e_ctrl});
    chk("bubble_cnt", {48'd0, bubble_cnt}, 64'(e_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic rand_fields();
    pc_in = $urandom; rd1_in = $urandom; rd2_in = $urandom; imm_in = $urandom;
    rs1_in = 5'($urandom_range(0, 3)); rs2_in = 5'($urandom_range(0, 3));
    rd_in = 5'($urandom); ctrl_in = 12'($urandom);
    wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;
  endtask

  initial begin
    logic [15:0] saved_cnt;
    model_clear(1'b1);

    // Reset state while rst held low from time zero.
    @(posedge clk); @(posedge clk); #1;
    check_all();
    @(negedge clk); rst = 1'b1;

    // Load something, then assert reset mid-cycle with busy inputs.
    rand_fields(); id_valid = 1'b1; step();
    rand_fields(); stall = 1'b1; flush = 1'b1;
    #2; rst = 1'b0; model_clear(1'b1); #1;
    check_all();
    chk("rst_async_valid", {63'd0, ex_valid}, 64'd0);
    step();
    @(negedge clk); rst = 1'b1;
    stall = 1'b0; flush = 1'b0; id_valid = 1'b1; pc_in = 32'h40;
    step();
    chk("rst_release_pc", {32'd0, pc_ex}, 64'h40);
    chk("rst_release_valid", {63'd0, ex_valid}, 64'd1);

    // Load then stall for three cycles with changing inputs.
    rand_fields(); wb_reg_write = 1'b0; rd1_in = 32'hA5A5A5A5; step();
    saved_cnt = bubble_cnt;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_fields(); id_valid = 1'($urandom); step();
      chk("stall_rd1_hold", {32'd0, rd1_ex}, 64'hA5A5A5A5);
    end
    chk("stall_cnt_hold", {48'd0, bubble_cnt}, {48'd0, saved_cnt});

    // Flush wins over stall.
    flush = 1'b1; ctrl_in = 12'hFFF; id_valid = 1'b1; step();
    chk("flush_valid", {63'd0, ex_valid}, 64'd0);
    chk("flush_ctrl", {52'd0, ctrl_ex}, 64'd0);
    chk("flush_cnt", {48'd0, bubble_cnt}, {48'd0, saved_cnt} + 64'd1);

    // Write-back bypass, then register 0 exclusion.
    stall = 1'b0; flush = 1'b0; id_valid = 1'b1;
    rs1_in = 5'd5; rd1_in = 32'h1; wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD;
    step();
`ifdef WB_BYPASS_EN
    chk("bypass_rd1", {32'd0, rd1_ex}, 64'hDEAD);
`else
    chk("nobypass_rd1", {32'd0, rd1_ex}, 64'h1);
`endif
    rs1_in = 5'd0; wb_rd = 5'd0; rd1_in = 32'h0; step();
    chk("bypass_x0_rd1", {32'd0, rd1_ex}, 64'h0);

    // Idle bubble with nonzero fields.
    rand_fields(); ctrl_in = 12'hABC; pc_in = 32'h1234; id_valid = 1'b0; step();
    chk("idle_valid", {63'd0, ex_valid}, 64'd0);
    chk("idle_pc", {32'd0, pc_ex}, 64'd0);
    chk("idle_ctrl", {52'd0, ctrl_ex}, 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 3) == 0);
      id_valid = ($urandom_range(0, 4) != 0);
      step();
    end

    // Long idle run drives the bubble counter into saturation.
    stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
      model_edge();
    end
    #1;
    check_all();
    chk("sat_cnt", {48'd0, bubble_cnt}, 64'hFFFF);
    flush = 1'b1; step();
    chk("sat_cnt_flush", {48'd0, bubble_cnt}, 64'hFFFF);
    flush = 1'b0; id_valid = 1'b1; rand_fields(); step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

ID/EX pipeline register for the pipelined CPU. It sits directly downstream of `registerFile` and the decoder. It captures the register-file read data (RD1/RD2), the immediate, the register addresses, the control word and the PC, and presents them to the EX stage one cycle later. It supports stall (hold) and flush (bubble insertion), plus an optional same-cycle write-back bypass. The bypass covers the register-file write-then-read window, where RD1/RD2 still show the old value.

## Interface
- `N`, 32, data/PC width
- `RN`, 5, register address width
- `CN`, 12, control word width; all-zero encodes a NOP

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous reset, active-low
- `stall`  in  1  hold all stage contents
- `flush`  in  1  load a bubble
- `id_valid`  in  1  ID stage holds a real instruction
- `pc_in`  in  N  PC of ID instruction
- `rd1_in`, `rd2_in`  in  N  register-file RD1/RD2
- `imm_in`  in  N  sign-extended immediate
- `rs1_in`, `rs2_in`, `rd_in`  in  RN  source/destination addresses (rs1/rs2 equal A1/A2 of `registerFile`)
- `ctrl_in`  in  CN  decoded control word
- `wb_reg_write`  in  1  WB stage write enable (same signal as `regWrite`)
- `wb_rd`  in  RN  WB destination (A3)
- `wb_data`  in  N  WB data (WD)
- `ex_valid`  out  1  EX holds a real instruction
- `pc_ex`, `rd1_ex`, `rd2_ex`, `imm_ex`  out  N  registered fields
- `rs1_ex`, `rs2_ex`, `rd_ex`  out  RN  registered addresses
- `ctrl_ex`  out  CN  registered control
- `bubble_cnt`  out  16  count of bubbles issued, saturating

## Operation
- Every rising edge applies exactly one action, in priority order:
  - `flush`: load a bubble.
  - `stall`: hold all fields, valid and counter unchanged.
  - `id_valid=0`: load a bubble.
  - Otherwise: load the ID fields and set `ex_valid=1`.
- A bubble sets `ex_valid=0` and zeroes all data, address and control outputs.
- `flush` and `stall` asserted together: flush wins.
- Operand selection on load:
  - `rd1_ex` takes `wb_data` when the bypass is compiled in, `wb_reg_write=1`, `wb_rd==rs1_in` and `rs1_in!=0`. Otherwise it takes `rd1_in`.
  - `rd2_ex` follows the same rule using `rs2_in`.
- Register 0 is never bypassed. When `rs1_in=0` with the bypass active, `rd1_ex` takes `rd1_in`, which is 0.
- Bypass is evaluated only on a load edge. Held (stalled) operands are never updated.
- `bubble_cnt` increments by 1 on every edge that loads a bubble, either by flush or by `id_valid=0`.
  - Saturates at 16'hFFFF.
  - Does not change on stall edges.
- No combinational path exists from any input to any output. All outputs are flops.

## Timing
- Latency is 1 cycle: fields present at edge k appear on the outputs after edge k.
- Reset: asserting `rst` low immediately (asynchronously) forces all outputs to 0.
  - This covers `ex_valid`, all fields and `bubble_cnt`.
  - Held while low; release is synchronous to the next rising edge.
- Reset mid-stall or mid-flush: reset wins. The first edge after release applies the normal priority rules.
- Bypass timing: WB writes the register file at the same edge that this block captures. The bypass therefore provides the post-write value, closing the one-cycle read-after-write gap.
- Stall may be held for any number of cycles. Outputs stay bit-stable throughout.

## Configuration
- `WB_BYPASS_EN` defined:
  - The write-back bypass muxes on `rd1_ex` and `rd2_ex` are present.
- `WB_BYPASS_EN` undefined:
  - `rd1_ex`/`rd2_ex` always load `rd1_in`/`rd2_in`.
  - `wb_reg_write`, `wb_rd` and `wb_data` are unused.
  - The register file must then be write-first, or the hazard unit must stall one extra cycle.

## Test plan
- Reset: drive inputs nonzero and pull `rst` low mid-cycle -> all outputs 0 before the next edge; after release with `id_valid=1`, `pc_in=32'h40` -> `pc_ex=32'h40`, `ex_valid=1` one edge later.
- Load/stall: load `rd1_in=32'hA5A5A5A5`, then stall 3 cycles while changing inputs -> `rd1_ex` stays `32'hA5A5A5A5`, `bubble_cnt` unchanged.
- Flush priority: `stall=1`, `flush=1`, `ctrl_in=12'hFFF` -> after the edge `ex_valid=0`, `ctrl_ex=0`, `bubble_cnt` +1.
- Bypass (`WB_BYPASS_EN`): `rs1_in=5`, `rd1_in=32'h1`, `wb_reg_write=1`, `wb_rd=5`, `wb_data=32'hDEAD` -> `rd1_ex=32'hDEAD`. Repeat with `rs1_in=0`, `wb_rd=0` -> `rd1_ex=0`. Without the macro -> `rd1_ex=32'h1`.
- Counter saturation: hold `id_valid=0` for 65540 cycles -> `bubble_cnt=16'hFFFF` and stays there.
- Idle bubble: `id_valid=0` with nonzero fields -> all outputs 0, `ex_valid=0`.
